// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one byte-wide RAM port between the instruction-cache refill path
// (INS owner) and the load/store unit (DATA owner). Multi-byte accesses are
// split into 1, 2 or 4 little-endian byte transfers.
//
// Ports
//   clk_in, rst_in              clock, asynchronous active-low reset
//   rdy_in                      global enable; low freezes everything
//   io_buffer_full              UART full; stalls writes into IO space
//   flush                       aborts in-flight reads, blocks new accepts
//   mem_din/mem_dout/mem_a/mem_wr   byte RAM port (mem_wr=1 means write)
//   if_req/if_addr/if_done/if_data  instruction refill (always 4 bytes)
//   ls_req/ls_wr/ls_size/ls_addr/ls_wdata/ls_done/ls_rdata  load/store
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        io_buffer_full,
    input  logic        flush,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner_data;   // 1 = DATA owns the transfer, 0 = INS
    logic        r_last_data;    // winner of the last contested arbitration
    logic [2:0]  r_k;            // bytes already completed
    logic [2:0]  r_n;            // bytes in this transfer
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rbuf;

    // Transfer length from the load/store size code; code 3 behaves as word.
    function automatic logic [2:0] len_of(input logic [1:0] size);
        logic [2:0] len;
        case (size)
            2'd0:    len = 3'd1;
            2'd1:    len = 3'd2;
            default: len = 3'd4;
        endcase
        return len;
    endfunction

    // Select one little-endian byte lane of a word.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    // Replace one little-endian byte lane of a word.
    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // Addresses with bits [17:16] set map onto the UART.
    function automatic logic is_io(input logic [31:0] a);
        return (a[17:16] == 2'b11);
    endfunction

    logic        w_both;
    logic        w_accept;
    logic        w_grant_data;
    logic        w_req_wr;
    logic [31:0] w_req_addr;
    logic [2:0]  w_req_n;
    logic [2:0]  w_k_inc;
    logic        w_last_byte;
    logic [31:0] w_cur_addr;
    logic [31:0] w_next_addr;
    logic [31:0] w_rbuf_next;

    assign w_both       = if_req && ls_req;
    // A done pulse still on the outputs blocks acceptance for that cycle.
    assign w_accept     = (r_state == ST_IDLE) && !flush && !if_done && !ls_done &&
                          (if_req || ls_req);
    // Under contention DATA wins unless DATA won the previous contest.
    assign w_grant_data = ls_req && !(if_req && r_last_data);
    assign w_req_wr     = w_grant_data && ls_wr;
    assign w_req_addr   = w_grant_data ? ls_addr : if_addr;
    assign w_req_n      = w_grant_data ? len_of(ls_size) : 3'd4;
    assign w_k_inc      = r_k + 3'd1;
    assign w_last_byte  = (w_k_inc == r_n);
    // 32-bit adds wrap naturally past 0xFFFFFFFF.
    assign w_cur_addr   = r_addr + {29'd0, r_k};
    assign w_next_addr  = r_addr + {29'd0, w_k_inc};
    assign w_rbuf_next  = put_byte(r_rbuf, r_k[1:0], mem_din);

    // Arbitration, byte sequencing and all registered outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= ST_IDLE;
            r_owner_data <= 1'b0;
            r_last_data  <= 1'b0;
            r_k          <= 3'd0;
            r_n          <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_rbuf       <= 32'd0;
            mem_dout     <= 8'd0;
            mem_a        <= 32'd0;
            mem_wr       <= 1'b0;
            if_done      <= 1'b0;
            if_data      <= 32'd0;
            ls_done      <= 1'b0;
            ls_rdata     <= 32'd0;
        end else if (rdy_in) begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner_data <= w_grant_data;
                        if (w_both) begin
                            r_last_data <= w_grant_data;
                        end
                        r_addr  <= w_req_addr;
                        r_n     <= w_req_n;
                        r_k     <= 3'd0;
                        r_wdata <= ls_wdata;
                        r_rbuf  <= 32'd0;
                        mem_a   <= w_req_addr;
                        if (w_req_wr) begin
                            r_state  <= ST_WRITE;
                            mem_dout <= ls_wdata[7:0];
                            mem_wr   <= !(is_io(w_req_addr) && io_buffer_full);
                        end else begin
                            r_state <= ST_READ;
                            mem_wr  <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_k     <= 3'd0;
                        mem_a   <= 32'd0;
                        mem_wr  <= 1'b0;
                    end else if (w_last_byte) begin
                        r_state <= ST_IDLE;
                        r_k     <= 3'd0;
                        mem_a   <= 32'd0;
                        if (r_owner_data) begin
                            ls_done  <= 1'b1;
                            ls_rdata <= w_rbuf_next;
                        end else begin
                            if_done <= 1'b1;
                            if_data <= w_rbuf_next;
                        end
                    end else begin
                        r_k    <= w_k_inc;
                        r_rbuf <= w_rbuf_next;
                        mem_a  <= w_next_addr;
                    end
                end
                ST_WRITE: begin
                    // mem_wr high means byte k went out this cycle; low means it
                    // was held back by a full UART and must be retried.
                    if (mem_wr) begin
                        if (w_last_byte) begin
                            r_state <= ST_IDLE;
                            r_k     <= 3'd0;
                            mem_a   <= 32'd0;
                            mem_wr  <= 1'b0;
                            ls_done <= 1'b1;
                        end else begin
                            r_k      <= w_k_inc;
                            mem_a    <= w_next_addr;
                            mem_dout <= byte_of(r_wdata, w_k_inc[1:0]);
                            mem_wr   <= !(is_io(w_next_addr) && io_buffer_full);
                        end
                    end else begin
                        mem_a    <= w_cur_addr;
                        mem_dout <= byte_of(r_wdata, r_k[1:0]);
                        mem_wr   <= !(is_io(w_cur_addr) && io_buffer_full);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_k     <= 3'd0;
                    mem_a   <= 32'd0;
                    mem_wr  <= 1'b0;
                end
            endcase
        end
    end

endmodule
